// File: rtl/ws2812b_pkg.sv
// Definitions shared by the LED pattern generator and the ws2812b serializer:
// FSM encoding, hue-wheel size and GRB field placement.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } led_state_t;

  localparam int HUE_MAX = 768;
  localparam int HUE_W   = 10;
  localparam int CH_W    = 8;

  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  // Both operands are already below HUE_MAX, so one conditional subtract is an exact mod.
  function automatic logic [HUE_W-1:0] hue_add(input logic [HUE_W-1:0] a,
                                               input logic [HUE_W-1:0] b);
    logic [HUE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (HUE_W+1)'(HUE_MAX)) begin
      sum = sum - (HUE_W+1)'(HUE_MAX);
    end
    return sum[HUE_W-1:0];
  endfunction

endpackage

// File: rtl/hue_to_grb.sv
// Colour wheel lookup (768 hue steps) followed by per-channel brightness scaling,
// producing a GRB word. Purely combinational.
module hue_to_grb
  import ws2812b_pkg::*;
(
  input  logic [HUE_W-1:0] hue,
  input  logic [CH_W-1:0]  bright,
  output logic [23:0]      grb
);

  logic [CH_W-1:0] s;
  logic [CH_W-1:0] r;
  logic [CH_W-1:0] g;
  logic [CH_W-1:0] b;
  logic [CH_W:0]   gain;

  // (c * (bright + 1)) >> 8 keeps full scale at bright=255 and zero at bright=0.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [CH_W:0]   k);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, k};
    return CH_W'(prod >> 8);
  endfunction

  always_comb begin
    s    = hue[CH_W-1:0];
    r    = '0;
    g    = '0;
    b    = '0;
    gain = {1'b0, bright} + 9'd1;
    if (hue < 10'd256) begin
      r = 8'd255 - s;
      g = s;
    end else if (hue < 10'd512) begin
      g = 8'd255 - s;
      b = s;
    end else begin
      r = s;
      b = 8'd255 - s;
    end
    grb                       = '0;
    grb[GRB_G_LSB +: CH_W]    = scale(g, gain);
    grb[GRB_R_LSB +: CH_W]    = scale(r, gain);
    grb[GRB_B_LSB +: CH_W]    = scale(b, gain);
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Rainbow frame generator: on each enabled frame tick, emits NUM_LEDS GRB pixels
// over a valid/ready stream, advancing the base hue after every completed frame.
module led_pattern_gen
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS        = 1,
  parameter int FRAME_DIV       = 540000,
  parameter int HUE_STEP        = 4,
  parameter int LED_HUE_SPACING = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  brightness,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [HUE_W-1:0] STEP     = HUE_W'(HUE_STEP % HUE_MAX);
  localparam logic [HUE_W-1:0] SPACING  = HUE_W'(LED_HUE_SPACING % HUE_MAX);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  led_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [HUE_W-1:0] frame_hue_reg, frame_hue_next;
  logic [HUE_W-1:0] led_hue_reg, led_hue_next;
  logic [CH_W-1:0]  bright_reg, bright_next;
  logic [23:0]      data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic [23:0]      grb;

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // The LED hue is carried incrementally, so the mod stays exact for any LED count.
  hue_to_grb u_wheel (
    .hue    (led_hue_reg),
    .bright (bright_reg),
    .grb    (grb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      frame_hue_reg <= '0;
      led_hue_reg   <= '0;
      bright_reg    <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      frame_hue_reg <= frame_hue_next;
      led_hue_reg   <= led_hue_next;
      bright_reg    <= bright_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_hue_next = frame_hue_reg;
    led_hue_next   = led_hue_reg;
    bright_next    = bright_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    last_next      = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tick && enable) begin
          bright_next  = brightness;
          idx_next     = '0;
          led_hue_next = frame_hue_reg;
          state_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_next  = grb;
        valid_next = 1'b1;
        last_next  = (idx_reg == IDX_LAST);
        state_next = ST_SEND;
      end
      ST_SEND: begin
        // Ticks seen here are simply not acted on; enable is only looked at in IDLE.
        if (valid_reg && pix_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (last_reg) begin
            frame_hue_next = hue_add(frame_hue_reg, STEP);
            state_next     = ST_IDLE;
          end else begin
            idx_next     = idx_reg + IDX_W'(1);
            led_hue_next = hue_add(led_hue_reg, SPACING);
            state_next   = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pix_data  = data_reg;
  assign pix_valid = valid_reg;
  assign pix_last  = last_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: a cycle-level protocol/colour model checks
// every cycle, and directed scenarios pin the model with hand-computed pixels.
module tb_led_pattern_gen;

  localparam int NUM_LEDS = 3;
  localparam int FDIV     = 100;
  localparam int HSTEP    = 4;
  localparam int HSPACE   = 256;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  brightness;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  int   m_frames  = 0;
  int   m_idx     = 0;
  int   m_bright  = 0;
  int   due       = 0;
  int   mcnt      = 0;
  int   hs_count  = 0;
  bit   m_busy    = 0;
  bit   holding   = 0;
  logic [23:0] held_data = '0;
  logic        held_last = 1'b0;
  logic [23:0] got_q[$];
  logic        got_last_q[$];

  led_pattern_gen #(
    .NUM_LEDS        (NUM_LEDS),
    .FRAME_DIV       (FDIV),
    .HUE_STEP        (HSTEP),
    .LED_HUE_SPACING (HSPACE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .brightness (brightness),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected GRB pixel from the wheel definition with plain integer arithmetic.
  function automatic logic [23:0] model_pixel(input int fidx, input int led, input int br);
    int h, s, r, g, b;
    h = (fidx * HSTEP + led * HSPACE) % 768;
    s = h % 256;
    if (h < 256)      begin r = 255 - s; g = s;       b = 0;       end
    else if (h < 512) begin r = 0;       g = 255 - s; b = s;       end
    else              begin r = s;       g = 0;       b = 255 - s; end
    r = (r * (br + 1)) / 256;
    g = (g * (br + 1)) / 256;
    b = (b * (br + 1)) / 256;
    return {g[7:0], r[7:0], b[7:0]};
  endfunction

  task automatic monitor_step();
    bit was_busy, exp_new;
    if (!rst_n) begin
      chk("rst_valid", 32'(pix_valid), 32'd0);
      chk("rst_data",  32'(pix_data),  32'd0);
      chk("rst_last",  32'(pix_last),  32'd0);
      m_frames = 0; m_idx = 0; due = 0; mcnt = 0; m_busy = 0; holding = 0;
    end else begin
      was_busy = m_busy;
      exp_new  = (due == 1);
      if (due != 0) due--;
      chk("valid", 32'(pix_valid), 32'(holding || exp_new));
      if (pix_valid && holding) begin
        chk("hold_data", 32'(pix_data), 32'(held_data));
        chk("hold_last", 32'(pix_last), 32'(held_last));
      end else if (pix_valid && exp_new) begin
        chk("pix_data", 32'(pix_data), 32'(model_pixel(m_frames, m_idx, m_bright)));
        chk("pix_last", 32'(pix_last), 32'(m_idx == NUM_LEDS - 1));
      end
      if (pix_valid && (holding || exp_new)) begin
        if (pix_ready) begin
          hs_count++;
          got_q.push_back(pix_data);
          got_last_q.push_back(pix_last);
          holding = 0;
          if (m_idx == NUM_LEDS - 1) begin
            m_frames++;
            m_busy = 0;
          end else begin
            m_idx++;
            due = 2;
          end
        end else begin
          holding   = 1;
          held_data = pix_data;
          held_last = pix_last;
        end
      end
      // a frame starts only on a tick seen while no frame is in progress
      if (!was_busy && mcnt == FDIV - 1 && enable) begin
        m_busy   = 1;
        due      = 2;
        m_idx    = 0;
        m_bright = int'(brightness);
      end
      mcnt = (mcnt == FDIV - 1) ? 0 : mcnt + 1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (m_frames < target && n < budget) begin
      step(1);
      n++;
    end
    chk(name, 32'(m_frames), 32'(target));
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!pix_valid && n < budget) begin
      step(1);
      n++;
    end
    chk(name, 32'(pix_valid), 32'd1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1, f1;
    rst_n      = 1'b0;
    enable     = 1'b0;
    pix_ready  = 1'b1;
    brightness = 8'hFF;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // reset state
    step(3);
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_data",  32'(pix_data),  32'd0);
    chk("reset_last",  32'(pix_last),  32'd0);
    rst_n = 1'b1;

    // first frame, full brightness
    enable = 1'b1;
    wait_frames(1, 300, "frame1_done");
    enable = 1'b0;
    chk("f1_px0", 32'(got_q[0]), 32'h00FF00);
    chk("f1_px1", 32'(got_q[1]), 32'hFF0000);
    chk("f1_px2", 32'(got_q[2]), 32'h0000FF);
    chk("f1_last0", 32'(got_last_q[0]), 32'd0);
    chk("f1_last1", 32'(got_last_q[1]), 32'd0);
    chk("f1_last2", 32'(got_last_q[2]), 32'd1);
    $display("frame1: %06h %06h %06h", got_q[0], got_q[1], got_q[2]);

    // brightness scaling, latched per frame
    brightness = 8'h7F;
    reset_pulse();
    got_q.delete();
    got_last_q.delete();
    enable = 1'b1;
    wait_frames(1, 300, "half_done");
    brightness = 8'h00;
    wait_frames(2, 200, "dark_done");
    enable = 1'b0;
    chk("half_px0", 32'(got_q[0]), 32'h007F00);
    chk("half_px1", 32'(got_q[1]), 32'h7F0000);
    chk("half_px2", 32'(got_q[2]), 32'h00007F);
    chk("dark_px0", 32'(got_q[3]), 32'h000000);
    chk("dark_px1", 32'(got_q[4]), 32'h000000);
    chk("dark_px2", 32'(got_q[5]), 32'h000000);
    $display("scaling: %06h %06h %06h / %06h", got_q[0], got_q[1], got_q[2], got_q[3]);

    // reset in the middle of SEND clears outputs immediately
    brightness = 8'hFF;
    pix_ready  = 1'b0;
    enable     = 1'b1;
    wait_valid(300, "midrst_wait");
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(pix_valid), 32'd0);
    chk("midrst_data",  32'(pix_data),  32'd0);
    chk("midrst_last",  32'(pix_last),  32'd0);
    step(2);
    enable = 1'b0;
    rst_n  = 1'b1;
    $display("mid-send reset: valid=%0b data=%06h", pix_valid, pix_data);

    // backpressure, dropped tick, enable dropped mid-frame
    enable = 1'b1;
    wait_valid(300, "bp_wait");
    c0 = hs_count;
    step(10);
    chk("bp_held_count", 32'(hs_count), 32'(c0));
    chk("bp_held_valid", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    step(1);
    pix_ready = 1'b0;
    chk("bp_one_xfer", 32'(hs_count), 32'(c0 + 1));
    step(120);
    chk("tick_hold_count", 32'(hs_count), 32'(c0 + 1));
    chk("tick_hold_valid", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    wait_frames(1, 20, "bp_frame_done");
    f1 = m_frames;
    wait_valid(150, "next_frame_wait");
    enable = 1'b0;
    c1 = hs_count;
    wait_frames(f1 + 1, 20, "en_off_frame_done");
    chk("en_off_pixels", 32'(hs_count), 32'(c1 + NUM_LEDS));
    step(300);
    chk("en_off_no_frame", 32'(m_frames), 32'(f1 + 1));
    chk("en_off_no_pixel", 32'(hs_count), 32'(c1 + NUM_LEDS));
    $display("backpressure/enable: handshakes=%0d frames=%0d", hs_count, m_frames);

    // hue wrap: frame 191 uses hue 764, frame 192 wraps to hue 0
    reset_pulse();
    got_q.delete();
    got_last_q.delete();
    enable = 1'b1;
    wait_frames(193, 193 * FDIV + 400, "wrap_frames");
    enable = 1'b0;
    chk("wrap_len", 32'(got_q.size()), 32'(193 * NUM_LEDS));
    if (got_q.size() == 193 * NUM_LEDS) begin
      chk("wrap_f191_px0", 32'(got_q[573]), 32'h00FC03);
      chk("wrap_f192_px0", 32'(got_q[576]), 32'h00FF00);
      $display("wrap: f191 px0=%06h f192 px0=%06h", got_q[573], got_q[576]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 1, meaning pixels emitted per frame (1..1024).
REQ-002 SHALL have parameter FRAME_DIV, default 540000, meaning clk cycles per frame tick (50 Hz at 27 MHz).
REQ-003 SHALL have parameter HUE_STEP, default 4, meaning the hue advance per frame (0..767).
REQ-004 SHALL have parameter LED_HUE_SPACING, default 256, meaning the hue offset between adjacent LEDs (0..767).
REQ-005 SHALL have port clk, input, 1, the single system clock (27 MHz).
REQ-006 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, which permits new frames while high.
REQ-008 SHALL have port brightness, input, 8, the global intensity, sampled at frame start.
REQ-009 SHALL have port pix_data, output, 24, a GRB pixel laid out as {G[23:16], R[15:8], B[7:0]}.
REQ-010 SHALL have port pix_valid, output, 1, meaning pix_data is valid.
REQ-011 SHALL have port pix_ready, input, 1, meaning the downstream ws2812b serializer accepts a pixel.
REQ-012 SHALL have port pix_last, output, 1, qualifying the final pixel of a frame.

Function
REQ-013 SHALL count frame ticks with a counter running 0..FRAME_DIV-1 and raising a 1-cycle tick at wrap; the counter SHALL run regardless of enable and state.
REQ-014 SHALL implement FSM IDLE -> LOAD -> SEND -> (LOAD | IDLE).
REQ-015 IDLE: on tick with enable=1, SHALL latch brightness, clear led_idx to 0 and go to LOAD; a tick with enable=0 SHALL be ignored.
REQ-016 LOAD: SHALL register pix_data for led_idx, assert pix_valid, set pix_last=(led_idx==NUM_LEDS-1) and go to SEND; this takes exactly 1 cycle.
REQ-017 SEND: SHALL hold pix_data, pix_valid and pix_last stable until the cycle with pix_valid&pix_ready (handshake); on that cycle SHALL deassert pix_valid next cycle.
REQ-018 After a handshake on a non-last pixel, SHALL increment led_idx and go to LOAD; pixel throughput is therefore 1 pixel per 2 cycles at most.
REQ-019 After a handshake on the last pixel, SHALL set frame_hue=(frame_hue+HUE_STEP) mod 768 and go to IDLE.
REQ-020 SHALL compute the LED hue as h=(frame_hue+led_idx*LED_HUE_SPACING) mod 768, with the mod computed exactly and no truncation error for any NUM_LEDS.
REQ-021 SHALL map the colour wheel using s=h[7:0]: for h<256, R=255-s, G=s, B=0; for 256<=h<512, R=0, G=255-s, B=s; for 512<=h<768, R=s, G=0, B=255-s.
REQ-022 SHALL scale each channel as c_out=(c*(bright+1))>>8 using a 17-bit intermediate; bright=255 SHALL yield c_out=c, and bright=0 SHALL yield c_out=c>>8 (i.e. 0).
REQ-023 Ticks arriving in LOAD/SEND SHALL be dropped, with no queueing.
REQ-024 Deassertion of enable mid-frame SHALL NOT abort the frame; the frame SHALL complete and the FSM SHALL then stay in IDLE.
REQ-025 pix_valid SHALL never be deasserted before its handshake.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, pix_valid=0, pix_last=0, pix_data=0, led_idx=0, frame_hue=0, tick counter=0 and latched brightness=0.
REQ-027 Reset mid-frame SHALL drop the in-flight pixel; after release, the first frame SHALL start at the next tick with frame_hue=0.

Structure
REQ-028 SHALL place the FSM state encoding, the HUE_MAX=768 constant and the GRB field positions in a shared package ws2812b_pkg, which is also used by the ws2812b serializer.
REQ-029 SHALL place the wheel-plus-scaling logic in the sub-module hue_to_grb (combinational inputs hue[9:0] and bright[7:0], output grb[23:0]).

Verification
REQ-030 Reset: rst_n=0 mid-SEND -> pix_valid=0, pix_data=0 and pix_last=0 in the same cycle.
REQ-031 Frame content: NUM_LEDS=3, FRAME_DIV=100, bright=255, pix_ready=1 -> pixels 0x00FF00, 0xFF0000, 0x0000FF, with pix_last only on the third.
REQ-032 Backpressure: pix_ready=0 for 10 cycles in SEND -> pix_data and pix_valid constant; then ready=1 -> exactly one transfer.
REQ-033 Scaling: hue 0, bright=0x7F -> 0x007F00; bright=0x00 -> 0x000000.
REQ-034 Wrap: HUE_STEP=4 with frame_hue=764 at end of frame -> next frame LED0 uses hue 0 (0x00FF00).
REQ-035 Dropped tick / enable: tick during SEND -> no extra frame; enable=0 mid-frame -> remaining pixels still sent, and no frame follows.
